// File: rtl/reg_fifo.sv
// Register-based circular FIFO with first-word fall-through read port,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module reg_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_pop   = rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (wr_en && w_full)
                r_overflow <= 1'b1;
            if (rd_en && w_empty)
                r_underflow <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the write is suppressed on flush.
    always_ff @(posedge clk) begin
        if (!rst && !clear && w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= CW'(AF_LEVEL));
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_reg_fifo.sv
// Directed self-checking bench for reg_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3).
module tb_reg_fifo;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_assert = 0;
    int n_fail   = 0;

    reg_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic [7:0] d,
                             input logic f, input logic e, input logic af,
                             input logic ov, input logic un);
        chk({tag, ".count"},       32'(count),       32'(c));
        chk({tag, ".rd_data"},     32'(rd_data),     32'(d));
        chk({tag, ".full"},        32'(full),        32'(f));
        chk({tag, ".empty"},       32'(empty),       32'(e));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".overflow"},    32'(overflow),    32'(ov));
        chk({tag, ".underflow"},   32'(underflow),   32'(un));
    endtask

    initial begin
        logic [7:0] exp_head;
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk_state("reset", 3'd0, 8'h00, 0, 1, 0, 0, 0);

        // Reset mid-stream at count=3
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        chk_state("pre_rst", 3'd3, 8'h01, 0, 0, 1, 0, 0);
        rst = 1'b1;
        step(1'b1, 8'h04, 1'b0);
        rst = 1'b0;
        chk_state("mid_rst", 3'd0, 8'h00, 0, 1, 0, 0, 0);

        // Fill to full
        step(1'b1, 8'h11, 1'b0);
        chk_state("push1", 3'd1, 8'h11, 0, 0, 0, 0, 0);
        step(1'b1, 8'h22, 1'b0);
        chk_state("push2", 3'd2, 8'h11, 0, 0, 0, 0, 0);
        step(1'b1, 8'h33, 1'b0);
        chk_state("push3", 3'd3, 8'h11, 0, 0, 1, 0, 0);
        step(1'b1, 8'h44, 1'b0);
        chk_state("push4", 3'd4, 8'h11, 1, 0, 1, 0, 0);

        // Push while full, then push+pop while full
        step(1'b1, 8'h55, 1'b0);
        chk_state("ovf_push", 3'd4, 8'h11, 1, 0, 1, 1, 0);
        step(1'b1, 8'h66, 1'b1);
        chk_state("full_pp", 3'd3, 8'h22, 0, 0, 1, 1, 0);
        step(1'b0, 8'h00, 1'b1);
        chk_state("pop2", 3'd2, 8'h33, 0, 0, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1);
        chk_state("pop3", 3'd1, 8'h44, 0, 0, 0, 1, 0);
        step(1'b0, 8'h00, 1'b1);
        chk_state("pop4", 3'd0, 8'h00, 0, 1, 0, 1, 0);

        clear = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clear = 1'b0;
        chk_state("clear1", 3'd0, 8'h00, 0, 1, 0, 0, 0);

        // Push+pop while empty
        step(1'b1, 8'hA5, 1'b1);
        chk_state("empty_pp", 3'd1, 8'hA5, 0, 0, 0, 0, 1);

        // Build count=2 with overflow set, then clear with a concurrent push
        step(1'b1, 8'hB6, 1'b0);
        step(1'b1, 8'hC7, 1'b0);
        step(1'b1, 8'hD8, 1'b0);
        chk_state("refill", 3'd4, 8'hA5, 1, 0, 1, 0, 1);
        step(1'b1, 8'hE9, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_state("pop_b6", 3'd3, 8'hB6, 0, 0, 1, 1, 1);
        step(1'b0, 8'h00, 1'b1);
        chk_state("pre_clr", 3'd2, 8'hC7, 0, 0, 0, 1, 1);
        clear = 1'b1;
        step(1'b1, 8'hFF, 1'b0);
        clear = 1'b0;
        chk_state("clear2", 3'd0, 8'h00, 0, 1, 0, 0, 0);
        step(1'b0, 8'h00, 1'b0);
        chk_state("idle", 3'd0, 8'h00, 0, 1, 0, 0, 0);

        // Streaming at count=2 across pointer wrap
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        chk_state("strm_pre", 3'd2, 8'h10, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'(8'h30 + 8'h10 * k), 1'b1);
            exp_head = (k == 0) ? 8'h20 : 8'(8'h30 + 8'h10 * (k - 1));
            chk($sformatf("strm%0d.count", k), 32'(count), 32'd2);
            chk($sformatf("strm%0d.rd_data", k), 32'(rd_data), 32'(exp_head));
        end
        step(1'b0, 8'h00, 1'b1);
        chk_state("drain1", 3'd1, 8'hC0, 0, 0, 0, 0, 0);
        step(1'b0, 8'h00, 1'b1);
        chk_state("drain2", 3'd0, 8'h00, 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
